// File: rtl/code_serializer.sv
// Parallel-to-serial front end: accepts a WIDTH-bit word on load&&ready and
// emits it one bit per clock on code, pulsing done with the final bit.
module code_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             code,
    output logic             code_valid,
    output logic             done
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic               code_q, code_d;
    logic               vld_q, vld_d;
    logic               done_q, done_d;
    logic               last_bit;
    logic               accept;

    function automatic logic head_bit(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
    endfunction

    always_comb begin
        last_bit = (state_q == S_SHIFT) && (cnt_q == LAST);
        ready    = !reset && ((state_q == S_IDLE) || last_bit);
        accept   = load && ready;

        state_d  = state_q;
        cnt_d    = cnt_q;
        sreg_d   = sreg_q;

        if (accept) begin
            state_d = S_SHIFT;
            cnt_d   = '0;
            sreg_d  = data_in;
        end else if (state_q == S_SHIFT) begin
            if (last_bit) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d  = cnt_q + CNT_W'(1);
                sreg_d = shift_once(sreg_q);
            end
        end

        // Outputs are registered: decode them from the next state so they
        // line up with the state they describe.
        code_d = (state_d == S_SHIFT) ? head_bit(sreg_d) : IDLE_LEVEL;
        vld_d  = (state_d == S_SHIFT);
        done_d = (state_d == S_SHIFT) && (cnt_d == LAST);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sreg_q  <= '0;
            code_q  <= IDLE_LEVEL;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            code_q  <= code_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
        end
    end

    assign code       = code_q;
    assign code_valid = vld_q;
    assign done       = done_q;

endmodule

// File: tb/tb_code_serializer.sv
// Bench for code_serializer: MSB-first and LSB-first instances share stimulus
// and are checked every cycle against a queue-of-pending-bits model.
module tb_code_serializer;

    localparam int W = 8;

    logic         clock   = 1'b0;
    logic         reset   = 1'b1;
    logic         load    = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         ready_m, code_m, vld_m, done_m;
    logic         ready_l, code_l, vld_l, done_l;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    code_serializer #(.WIDTH(W), .MSB_FIRST(1), .IDLE_LEVEL(0)) dut_m (
        .clock(clock), .reset(reset), .data_in(data_in), .load(load),
        .ready(ready_m), .code(code_m), .code_valid(vld_m), .done(done_m)
    );

    code_serializer #(.WIDTH(W), .MSB_FIRST(0), .IDLE_LEVEL(0)) dut_l (
        .clock(clock), .reset(reset), .data_in(data_in), .load(load),
        .ready(ready_l), .code(code_l), .code_valid(vld_l), .done(done_l)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: each queue holds the bits still to appear on code, the head
    // being the one shown in the current cycle.
    bit pm[$];
    bit pl[$];

    always @(posedge clock) begin
        bit acc;
        acc = load && !reset && (pm.size() <= 1);
        if (reset) begin
            pm.delete();
            pl.delete();
        end else begin
            if (pm.size() > 0) begin
                void'(pm.pop_front());
                void'(pl.pop_front());
            end
            if (acc) begin
                for (int k = 0; k < W; k++) begin
                    pm.push_back(data_in[W-1-k]);
                    pl.push_back(data_in[k]);
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            bit ev, ecm, ecl, ed, er;
            ev  = (pm.size() > 0);
            ecm = ev ? pm[0] : 1'b0;
            ecl = ev ? pl[0] : 1'b0;
            ed  = (pm.size() == 1);
            er  = !reset && (pm.size() <= 1);
            chk("m_code",  code_m,  ecm);
            chk("m_valid", vld_m,   ev);
            chk("m_done",  done_m,  ed);
            chk("m_ready", ready_m, er);
            chk("l_code",  code_l,  ecl);
            chk("l_valid", vld_l,   ev);
            chk("l_done",  done_l,  ed);
            chk("l_ready", ready_l, er);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [W-1:0] w);
        load    = 1'b1;
        data_in = w;
        for (int i = 0; i < 4 * W; i++) begin
            if (ready_m) break;
            tick();
        end
        chk("send_ready", ready_m, 1);
        tick();
        load = 1'b0;
    endtask

    task automatic word_check(input string nm, input logic [W-1:0] w,
                              input logic [W-1:0] exp_m, input logic [W-1:0] exp_l);
        send(w);
        for (int k = 0; k < W; k++) begin
            @(negedge clock);
            chk({nm, "_mbit"}, code_m, exp_m[W-1-k]);
            chk({nm, "_lbit"}, code_l, exp_l[W-1-k]);
            chk({nm, "_vld"},  vld_m,  1);
            chk({nm, "_done"}, done_m, (k == W - 1));
            tick();
        end
        @(negedge clock);
        chk({nm, "_idle_code"}, code_m, 0);
        chk({nm, "_idle_vld"},  vld_m,  0);
        chk({nm, "_idle_rdy"},  ready_m, 1);
        tick();
    endtask

    initial begin
        logic [W-1:0] busy_exp;

        // Reset held across two edges, then released.
        reset = 1'b1;
        tick();
        chk_en = 1'b1;
        @(negedge clock);
        chk("rst_ready", ready_m, 0);
        chk("rst_code",  code_m,  0);
        chk("rst_vld",   vld_m,   0);
        chk("rst_done",  done_m,  0);
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("rel_ready", ready_m, 1);
        tick();

        word_check("b2", 8'hB2, 8'b1011_0010, 8'b0100_1101);

        // Back-to-back: FF then 00 chained in the last-bit cycle.
        send(8'hFF);
        data_in = 8'h00;
        load    = 1'b1;
        for (int k = 0; k <= 2 * W; k++) begin
            @(negedge clock);
            if (k < 2 * W) begin
                chk("b2b_vld",  vld_m,  1);
                chk("b2b_code", code_m, (k < W));
                chk("b2b_done", done_m, (k == W - 1) || (k == 2 * W - 1));
            end else begin
                chk("b2b_end_vld", vld_m, 0);
            end
            if (k == W - 1) chk("b2b_ready", ready_m, 1);
            tick();
            if (k == W - 1) load = 1'b0;
        end

        // Load while busy: 3C offered during bit 3 must be ignored.
        busy_exp = 8'hA5;
        send(8'hA5);
        for (int k = 0; k < W; k++) begin
            if (k == 3) begin
                load    = 1'b1;
                data_in = 8'h3C;
            end
            if (k == 4) load = 1'b0;
            @(negedge clock);
            chk("busy_code", code_m, busy_exp[W-1-k]);
            if (k == 3) chk("busy_ready", ready_m, 0);
            tick();
        end
        @(negedge clock);
        chk("busy_idle_vld", vld_m, 0);
        tick();

        // Reset during bit 2 abandons the word.
        send(8'hF0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            tick();
        end
        reset = 1'b1;
        @(negedge clock);
        chk("mid_ready", ready_m, 0);
        chk("mid_vld",   vld_m,   1);
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("mid_after_code", code_m, 0);
        chk("mid_after_vld",  vld_m,  0);
        chk("mid_after_done", done_m, 0);
        chk("mid_after_rdy",  ready_m, 1);
        tick();
        word_check("w81", 8'h81, 8'b1000_0001, 8'b1000_0001);

        // Random traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            reset   = ($urandom_range(0, 59) == 0);
            load    = ($urandom_range(0, 3) != 0);
            data_in = W'($urandom);
            tick();
        end
        reset = 1'b0;
        load  = 1'b0;
        for (int c = 0; c < 2 * W; c++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
        $fatal(1);
    end

endmodule
